// File: rtl/spi_accel_responder_if.sv
// spi_accel_responder_if
// Four-wire SPI link between an SPI master and the accelerometer responder.
//   sck_i  : SPI clock, mode 0, driven by the master
//   ncs_i  : chip select, active-low, driven by the master
//   mosi_i : master-to-target serial data, MSB first
//   miso_o : target-to-master serial data, MSB first
interface spi_accel_responder_if;
  logic sck_i;
  logic ncs_i;
  logic mosi_i;
  logic miso_o;

  modport master (output sck_i, output ncs_i, output mosi_i, input miso_o);
  modport slave  (input sck_i, input ncs_i, input mosi_i, output miso_o);
endinterface

// File: rtl/spi_accel_responder.sv
// spi_accel_responder
// SPI target answering the accelerometer register protocol: command 0x0A
// writes and 0x0B reads a 64-byte register map with auto-incrementing,
// wrapping addresses. Samples arrive on parallel inputs and raise int1/int2
// through DATA_READY and the INTMAP registers.
// Ports:
//   clk          : system clock, at least 8x the SCK frequency
//   reset        : asynchronous active-low reset
//   spi          : SPI link (slave modport), pins asynchronous to clk
//   sample_valid : one-clk strobe, new sample on x_data/y_data/z_data
//   x/y/z_data   : 12-bit signed samples
//   int1, int2   : DATA_READY masked by INTMAP1[0] / INTMAP2[0], registered
module spi_accel_responder (
  input  logic                 clk,
  input  logic                 reset,
  spi_accel_responder_if.slave spi,
  input  logic                 sample_valid,
  input  logic [11:0]          x_data,
  input  logic [11:0]          y_data,
  input  logic [11:0]          z_data,
  output logic                 int1,
  output logic                 int2
);
  localparam logic [7:0] DEVID_AD       = 8'hAD;
  localparam logic [7:0] DEVID_MST      = 8'h1D;
  localparam logic [7:0] PARTID         = 8'hF2;
  localparam logic [7:0] REVID          = 8'h01;
  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR_W, ST_ADDR_R, ST_DATA_W, ST_DATA_R, ST_IGNORE
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  sck_sync_r, ncs_sync_r, mosi_sync_r;
  logic        sck_prev_r, ncs_prev_r;
  logic        sck_rise_s, sck_fall_s, ncs_rise_s, ncs_fall_s;
  logic [2:0]  bit_cnt_r;
  logic [6:0]  shift_in_r;
  logic [7:0]  byte_s;
  logic        byte_done_s;
  logic [5:0]  addr_r, rd_addr_s;
  logic [7:0]  rd_data_s, shift_out_r;
  logic        miso_r;
  logic [7:0]  gp_r [0:15];
  logic        data_ready_r;
  logic [11:0] x_live_r, y_live_r, z_live_r;
  logic [11:0] x_shadow_r, y_shadow_r, z_shadow_r;
  logic        wr_en_s, srst_s, rd_clr_s;
  logic        int1_r, int2_r;

  // Sample registers whose read-out consumes DATA_READY.
  function automatic logic is_sample_addr_f(input logic [5:0] a);
    return ((a >= 6'h08) && (a <= 6'h0A)) || ((a >= 6'h0E) && (a <= 6'h13));
  endfunction

  // Upper byte of a 12-bit sample, sign-extended.
  function automatic logic [7:0] hi_byte_f(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

  // Two-flop synchronisers plus previous-value flops for edge detection.
  // ncs resets low so a chip select held low across reset is not seen as a
  // fresh falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_r  <= 2'b00;
      ncs_sync_r  <= 2'b00;
      mosi_sync_r <= 2'b00;
      sck_prev_r  <= 1'b0;
      ncs_prev_r  <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[0], spi.sck_i};
      ncs_sync_r  <= {ncs_sync_r[0], spi.ncs_i};
      mosi_sync_r <= {mosi_sync_r[0], spi.mosi_i};
      sck_prev_r  <= sck_sync_r[1];
      ncs_prev_r  <= ncs_sync_r[1];
    end
  end

  assign sck_rise_s  = sck_sync_r[1] & ~sck_prev_r;
  assign sck_fall_s  = ~sck_sync_r[1] & sck_prev_r;
  assign ncs_rise_s  = ncs_sync_r[1] & ~ncs_prev_r;
  assign ncs_fall_s  = ~ncs_sync_r[1] & ncs_prev_r;
  assign byte_s      = {shift_in_r, mosi_sync_r[1]};
  assign byte_done_s = sck_rise_s & (bit_cnt_r == 3'd7) & (state_r != ST_IDLE) & ~ncs_rise_s;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: chip-select release aborts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (ncs_rise_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   if (ncs_fall_s) state_nxt_s = ST_CMD; else state_nxt_s = ST_IDLE;
        ST_CMD: begin
          if (!byte_done_s)            state_nxt_s = ST_CMD;
          else if (byte_s == CMD_WRITE) state_nxt_s = ST_ADDR_W;
          else if (byte_s == CMD_READ)  state_nxt_s = ST_ADDR_R;
          else                          state_nxt_s = ST_IGNORE;
        end
        ST_ADDR_W: if (byte_done_s) state_nxt_s = ST_DATA_W; else state_nxt_s = ST_ADDR_W;
        ST_ADDR_R: if (byte_done_s) state_nxt_s = ST_DATA_R; else state_nxt_s = ST_ADDR_R;
        default:   state_nxt_s = state_r;
      endcase
    end
  end

  // Bit counter and MOSI shifter; a partial byte is dropped when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r  <= 3'd0;
      shift_in_r <= 7'd0;
    end else if ((state_r == ST_IDLE) || ncs_rise_s) begin
      bit_cnt_r  <= 3'd0;
      shift_in_r <= 7'd0;
    end else if (sck_rise_s) begin
      bit_cnt_r  <= bit_cnt_r + 3'd1;
      shift_in_r <= byte_s[6:0];
    end
  end

  // Address of the byte to prefetch: the received address in ADDR_R,
  // otherwise the byte after the one just shifted out.
  always_comb begin
    rd_addr_s = addr_r + 6'd1;
    if (state_r == ST_ADDR_R) begin
      rd_addr_s = byte_s[5:0];
    end else begin
      rd_addr_s = addr_r + 6'd1;
    end
  end

  // Register map read mux; sample bytes come from the transaction shadow.
  always_comb begin
    rd_data_s = 8'h00;
    case (rd_addr_s)
      6'h00:   rd_data_s = DEVID_AD;
      6'h01:   rd_data_s = DEVID_MST;
      6'h02:   rd_data_s = PARTID;
      6'h03:   rd_data_s = REVID;
      6'h08:   rd_data_s = x_shadow_r[11:4];
      6'h09:   rd_data_s = y_shadow_r[11:4];
      6'h0A:   rd_data_s = z_shadow_r[11:4];
      6'h0B:   rd_data_s = {7'd0, data_ready_r};
      6'h0E:   rd_data_s = x_shadow_r[7:0];
      6'h0F:   rd_data_s = hi_byte_f(x_shadow_r);
      6'h10:   rd_data_s = y_shadow_r[7:0];
      6'h11:   rd_data_s = hi_byte_f(y_shadow_r);
      6'h12:   rd_data_s = z_shadow_r[7:0];
      6'h13:   rd_data_s = hi_byte_f(z_shadow_r);
      default: begin
        if ((rd_addr_s >= 6'h20) && (rd_addr_s <= 6'h2E)) rd_data_s = gp_r[rd_addr_s[3:0]];
        else rd_data_s = 8'h00;
      end
    endcase
  end

  // Address pointer and MISO shift register: load on byte completion,
  // shift on SCK fall so each bit is set up before the master's rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r      <= 6'd0;
      shift_out_r <= 8'h00;
    end else begin
      if (byte_done_s && ((state_r == ST_ADDR_W) || (state_r == ST_ADDR_R))) begin
        addr_r <= byte_s[5:0];
      end else if (byte_done_s && ((state_r == ST_DATA_W) || (state_r == ST_DATA_R))) begin
        addr_r <= addr_r + 6'd1;
      end
      if (byte_done_s && ((state_r == ST_ADDR_R) || (state_r == ST_DATA_R))) begin
        shift_out_r <= rd_data_s;
      end else if (sck_fall_s && (state_r == ST_DATA_R)) begin
        shift_out_r <= {shift_out_r[6:0], 1'b0};
      end
    end
  end

  // Registered MISO, forced low outside a read data phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miso_r <= 1'b0;
    end else if ((state_r != ST_DATA_R) || ncs_rise_s) begin
      miso_r <= 1'b0;
    end else if (sck_fall_s) begin
      miso_r <= shift_out_r[7];
    end
  end

  assign wr_en_s  = byte_done_s & (state_r == ST_DATA_W);
  assign srst_s   = wr_en_s & (addr_r == 6'h1F) & (byte_s == SOFT_RESET_KEY);
  assign rd_clr_s = byte_done_s & (state_r == ST_DATA_R) & is_sample_addr_f(addr_r);

  // General-purpose registers 0x20-0x2E; entry 15 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) gp_r[i] <= 8'h00;
    end else if (srst_s) begin
      for (int i = 0; i < 16; i++) gp_r[i] <= 8'h00;
    end else if (wr_en_s && (addr_r >= 6'h20) && (addr_r <= 6'h2E)) begin
      gp_r[addr_r[3:0]] <= byte_s;
    end
  end

  // DATA_READY: a new sample wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_ready_r <= 1'b0;
    end else if (sample_valid) begin
      data_ready_r <= 1'b1;
    end else if (srst_s || rd_clr_s) begin
      data_ready_r <= 1'b0;
    end
  end

  // Live samples, and a shadow frozen at chip-select fall for coherent bursts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_live_r   <= 12'd0;
      y_live_r   <= 12'd0;
      z_live_r   <= 12'd0;
      x_shadow_r <= 12'd0;
      y_shadow_r <= 12'd0;
      z_shadow_r <= 12'd0;
    end else begin
      if (sample_valid) begin
        x_live_r <= x_data;
        y_live_r <= y_data;
        z_live_r <= z_data;
      end
      if (ncs_fall_s) begin
        x_shadow_r <= x_live_r;
        y_shadow_r <= y_live_r;
        z_shadow_r <= z_live_r;
      end
    end
  end

  // Registered interrupt outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int1_r <= 1'b0;
      int2_r <= 1'b0;
    end else begin
      int1_r <= data_ready_r & gp_r[4'hA][0];
      int2_r <= data_ready_r & gp_r[4'hB][0];
    end
  end

  assign spi.miso_o = miso_r;
  assign int1       = int1_r;
  assign int2       = int2_r;
endmodule

// File: tb/tb_spi_accel_responder.sv
// tb_spi_accel_responder
// Drives SPI transactions as a mode-0 master and checks read data, interrupts
// and register side effects against a register-map model held in the bench.
module tb_spi_accel_responder;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] x_data, y_data, z_data;
  logic        int1, int2;

  spi_accel_responder_if spi_bus ();

  spi_accel_responder dut (
    .clk(clk), .reset(reset), .spi(spi_bus), .sample_valid(sample_valid),
    .x_data(x_data), .y_data(y_data), .z_data(z_data), .int1(int1), .int2(int2)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  m_gp [0:63];
  logic        m_dr;
  logic [11:0] m_x, m_y, m_z;
  logic [7:0]  wr_q [$];
  logic [7:0]  rd_q [$];
  logic [7:0]  exp_q [$];
  logic        mon_en = 1'b0;
  logic        miso_seen = 1'b0;

  always @(negedge clk) if (mon_en && (spi_bus.miso_o !== 1'b0)) miso_seen = 1'b1;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] axis_top(logic [11:0] s);
    return 8'(int'(s) / 16);
  endfunction
  function automatic logic [7:0] axis_lo(logic [11:0] s);
    return 8'(int'(s) % 256);
  endfunction
  function automatic logic [7:0] axis_hi(logic [11:0] s);
    int v;
    v = (int'(s) >= 2048) ? int'(s) - 4096 : int'(s);
    return 8'(v >>> 8);
  endfunction
  function automatic bit is_sample(int a);
    return (a >= 8 && a <= 10) || (a >= 14 && a <= 19);
  endfunction

  function automatic logic [7:0] m_read(int a, logic [11:0] sx, logic [11:0] sy, logic [11:0] sz);
    logic [11:0] ax [3];
    ax[0] = sx; ax[1] = sy; ax[2] = sz;
    if (a == 0) return 8'hAD;
    else if (a == 1) return 8'h1D;
    else if (a == 2) return 8'hF2;
    else if (a == 3) return 8'h01;
    else if (a >= 8 && a <= 10) return axis_top(ax[a-8]);
    else if (a == 11) return {7'd0, m_dr};
    else if (a >= 14 && a <= 19) return ((a - 14) % 2 == 0) ? axis_lo(ax[(a-14)/2]) : axis_hi(ax[(a-14)/2]);
    else if (a >= 32 && a <= 46) return m_gp[a];
    else return 8'h00;
  endfunction

  function automatic void m_write(int a, logic [7:0] d);
    if (a >= 32 && a <= 46) m_gp[a] = d;
    else if (a == 31 && d == 8'h52) begin
      for (int i = 32; i <= 46; i++) m_gp[i] = 8'h00;
      m_dr = 1'b0;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_gp[i] = 8'h00;
    m_dr = 1'b0; m_x = 12'd0; m_y = 12'd0; m_z = 12'd0;
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi_bus.mosi_i = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = spi_bus.miso_o;
      spi_bus.sck_i = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_bus.sck_i = 1'b0;
    end
  endtask

  task automatic spi_start();
    @(negedge clk);
    spi_bus.ncs_i = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_stop();
    repeat (HALF) @(negedge clk);
    spi_bus.ncs_i = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic pulse_sample(input logic [11:0] sx, input logic [11:0] sy, input logic [11:0] sz);
    @(negedge clk);
    x_data = sx; y_data = sy; z_data = sz; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_x = sx; m_y = sy; m_z = sz; m_dr = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] addr);
    logic [7:0] rx;
    int a;
    spi_start();
    spi_bits(8'h0A, 8, rx);
    spi_bits(addr, 8, rx);
    a = int'(addr[5:0]);
    foreach (wr_q[i]) begin
      spi_bits(wr_q[i], 8, rx);
      m_write(a, wr_q[i]);
      a = (a + 1) % 64;
    end
    spi_stop();
  endtask

  // Reads n bytes into rd_q; exp_q gets the model's view of the same bytes.
  task automatic do_read(input logic [7:0] addr, input int n);
    logic [7:0] rx;
    int a;
    rd_q.delete(); exp_q.delete();
    spi_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(addr, 8, rx);
    for (int j = 0; j < n; j++) begin
      a = (int'(addr[5:0]) + j) % 64;
      spi_bits(8'($urandom_range(0, 255)), 8, rx);
      rd_q.push_back(rx);
      exp_q.push_back(m_read(a, m_x, m_y, m_z));
      if (is_sample(a)) m_dr = 1'b0;
    end
    spi_stop();
  endtask

  task automatic test_reset();
    reset = 1'b0; sample_valid = 1'b0; x_data = 12'd0; y_data = 12'd0; z_data = 12'd0;
    spi_bus.sck_i = 1'b0; spi_bus.ncs_i = 1'b1; spi_bus.mosi_i = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    n_checks++; if (spi_bus.miso_o !== 1'b0) begin n_errors++; $display("FAIL reset_miso: got %b expected 0", spi_bus.miso_o); end
    n_checks++; if (int1 !== 1'b0) begin n_errors++; $display("FAIL reset_int1: got %b expected 0", int1); end
    n_checks++; if (int2 !== 1'b0) begin n_errors++; $display("FAIL reset_int2: got %b expected 0", int2); end
    reset = 1'b1;
    repeat (8) @(negedge clk);
    do_read(8'h0B, 1);
    n_checks++; if (rd_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL reset_status: got %02h expected %02h", rd_q[0], exp_q[0]); end
  endtask

  task automatic test_id_read();
    logic [7:0] rx;
    spi_start();
    spi_bits(8'h0B, 8, rx);
    n_checks++; if (rx !== 8'h00) begin n_errors++; $display("FAIL id_cmd_miso: got %02h expected 00", rx); end
    spi_bits(8'h00, 8, rx);
    n_checks++; if (rx !== 8'h00) begin n_errors++; $display("FAIL id_addr_miso: got %02h expected 00", rx); end
    for (int j = 0; j < 4; j++) begin
      spi_bits(8'($urandom_range(0, 255)), 8, rx);
      n_checks++;
      if (rx !== m_read(j, m_x, m_y, m_z)) begin
        n_errors++; $display("FAIL id_byte%0d: got %02h expected %02h", j, rx, m_read(j, m_x, m_y, m_z));
      end
    end
    spi_stop();
  endtask

  task automatic test_write_readback();
    wr_q = '{8'h01};
    do_write(8'h2A);
    do_read(8'h2A, 1);
    n_checks++; if (rd_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL intmap1_readback: got %02h expected %02h", rd_q[0], exp_q[0]); end
    pulse_sample(12'h123, 12'($urandom), 12'($urandom));
    @(negedge clk);
    n_checks++; if (int1 !== (m_dr & m_gp[42][0])) begin n_errors++; $display("FAIL int1_assert: got %b expected %b", int1, m_dr & m_gp[42][0]); end
    n_checks++; if (int2 !== (m_dr & m_gp[43][0])) begin n_errors++; $display("FAIL int2_quiet: got %b expected %b", int2, m_dr & m_gp[43][0]); end
    for (int r = 0; r < 3; r++) begin
      wr_q.delete();
      repeat ($urandom_range(1, 4)) wr_q.push_back(8'($urandom_range(0, 255)));
      do_write(8'($urandom_range(32, 46)));
      do_read(8'h20, 15);
      for (int j = 0; j < 15; j++) begin
        n_checks++;
        if (rd_q[j] !== exp_q[j]) begin n_errors++; $display("FAIL gp_readback r%0d reg%02h: got %02h expected %02h", r, 32 + j, rd_q[j], exp_q[j]); end
      end
    end
  endtask

  task automatic test_coherent_burst();
    logic [7:0]  rx, ex;
    logic [11:0] sx, sy, sz;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) pulse_sample(12'h8F0, 12'h7FF, 12'h001);
      else pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
      sx = m_x; sy = m_y; sz = m_z;
      spi_start();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h0E, 8, rx);
      for (int j = 0; j < 6; j++) begin
        spi_bits(8'($urandom_range(0, 255)), 8, rx);
        ex = m_read(14 + j, sx, sy, sz);
        n_checks++;
        if (rx !== ex) begin n_errors++; $display("FAIL burst it%0d byte%0d: got %02h expected %02h", it, j, rx, ex); end
        m_dr = 1'b0;
        if (it == 0 && (j == 2 || j == 5)) pulse_sample(12'd0, 12'd0, 12'd0);
        else if (j == 2) pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
        else if (j == 5) pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
      end
      spi_stop();
      n_checks++; if (int1 !== (m_dr & m_gp[42][0])) begin n_errors++; $display("FAIL burst_int1 it%0d: got %b expected %b", it, int1, m_dr & m_gp[42][0]); end
      do_read(8'h0B, 1);
      n_checks++; if (rd_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL burst_status it%0d: got %02h expected %02h", it, rd_q[0], exp_q[0]); end
      do_read(8'h08, 3);
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (rd_q[j] !== exp_q[j]) begin n_errors++; $display("FAIL hires it%0d byte%0d: got %02h expected %02h", it, j, rd_q[j], exp_q[j]); end
      end
    end
  endtask

  task automatic test_wrap_readonly();
    wr_q = '{8'hAA, 8'h55};
    do_write(8'h3F);
    do_read(8'h00, 1);
    n_checks++; if (rd_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL wrap_devid: got %02h expected %02h", rd_q[0], exp_q[0]); end
    do_read(8'h3F, 2);
    n_checks++; if (rd_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL wrap_3f: got %02h expected %02h", rd_q[0], exp_q[0]); end
    n_checks++; if (rd_q[1] !== exp_q[1]) begin n_errors++; $display("FAIL wrap_to_00: got %02h expected %02h", rd_q[1], exp_q[1]); end
  endtask

  task automatic test_resets();
    logic [7:0] rx, v;
    wr_q.delete();
    for (int i = 0; i < 15; i++) wr_q.push_back(8'($urandom_range(0, 255)));
    wr_q[0] = 8'hFF; wr_q[10] = wr_q[10] | 8'h01;
    do_write(8'h20);
    pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
    @(negedge clk);
    n_checks++; if (int1 !== (m_dr & m_gp[42][0])) begin n_errors++; $display("FAIL pre_reset_int1: got %b expected %b", int1, m_dr & m_gp[42][0]); end
    spi_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'h00, 3, rx);
    reset = 1'b0;
    #1;
    n_checks++; if (spi_bus.miso_o !== 1'b0) begin n_errors++; $display("FAIL async_reset_miso: got %b expected 0", spi_bus.miso_o); end
    n_checks++; if (int1 !== 1'b0) begin n_errors++; $display("FAIL async_reset_int1: got %b expected 0", int1); end
    m_reset();
    repeat (3) @(negedge clk);
    spi_bus.ncs_i = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    do_read(8'h20, 15);
    for (int j = 0; j < 15; j++) begin
      n_checks++;
      if (rd_q[j] !== exp_q[j]) begin n_errors++; $display("FAIL async_reset_reg%02h: got %02h expected %02h", 32 + j, rd_q[j], exp_q[j]); end
    end
    wr_q.delete();
    for (int i = 0; i < 15; i++) wr_q.push_back(8'($urandom_range(0, 255)));
    wr_q[10] = wr_q[10] | 8'h01;
    do_write(8'h20);
    pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
    v = 8'($urandom_range(0, 255));
    if (v == 8'h52) v = 8'h53;
    wr_q = '{v};
    do_write(8'h1F);
    n_checks++; if (int1 !== (m_dr & m_gp[42][0])) begin n_errors++; $display("FAIL bad_key_int1: got %b expected %b", int1, m_dr & m_gp[42][0]); end
    wr_q = '{8'h52};
    do_write(8'h1F);
    n_checks++; if (int1 !== (m_dr & m_gp[42][0])) begin n_errors++; $display("FAIL soft_reset_int1: got %b expected %b", int1, m_dr & m_gp[42][0]); end
    do_read(8'h20, 15);
    for (int j = 0; j < 15; j++) begin
      n_checks++;
      if (rd_q[j] !== exp_q[j]) begin n_errors++; $display("FAIL soft_reset_reg%02h: got %02h expected %02h", 32 + j, rd_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_abort_illegal();
    logic [7:0] rx;
    spi_start();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h21, 8, rx);
    spi_bits(8'h77, 5, rx);
    spi_stop();
    do_read(8'h21, 1);
    n_checks++; if (rd_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL abort_reg21: got %02h expected %02h", rd_q[0], exp_q[0]); end
    miso_seen = 1'b0;
    mon_en = 1'b1;
    spi_start();
    spi_bits(8'h0D, 8, rx);
    spi_bits(8'h00, 8, rx);
    for (int j = 0; j < 3; j++) begin
      spi_bits(8'($urandom_range(0, 255)), 8, rx);
      n_checks++; if (rx !== 8'h00) begin n_errors++; $display("FAIL illegal_byte%0d: got %02h expected 00", j, rx); end
    end
    spi_stop();
    mon_en = 1'b0;
    n_checks++; if (miso_seen !== 1'b0) begin n_errors++; $display("FAIL illegal_miso_high: got %b expected 0", miso_seen); end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_write_readback();
    test_coherent_burst();
    test_wrap_readonly();
    test_resets();
    test_abort_illegal();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_accel_responder.md
# spi_accel_responder

SPI target that answers the accelerometer register protocol driven by the SoC's SPI master peripheral (`pb_spi`). It gives a simulation and FPGA loopback counterpart for the PmodACL2 link. It decodes write-register (0x0A) and read-register (0x0B) commands into a 64-byte register file with auto-incrementing addresses. It captures X/Y/Z samples from parallel inputs and raises `int1`/`int2` on data-ready.

## Interface
- `DEVID_AD`, 8'hAD, value of reg 0x00 (read-only)
- `DEVID_MST`, 8'h1D, value of reg 0x01 (read-only)
- `PARTID`, 8'hF2, value of reg 0x02 (read-only)
- `REVID`, 8'h01, value of reg 0x03 (read-only)

Ports:
- `clk`  in  1  system clock; must be at least 8x the SCK frequency
- `reset`  in  1  asynchronous, active-low reset
- `sck_i`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`
- `ncs_i`  in  1  chip select, active-low, asynchronous
- `mosi_i`  in  1  serial data from master, MSB first
- `miso_o`  out  1  serial data to master, MSB first
- `sample_valid`  in  1  one-`clk` strobe: new sample present on `x_data`/`y_data`/`z_data`
- `x_data`, `y_data`, `z_data`  in  12 each  signed samples
- `int1`  out  1  DATA_READY & INTMAP1[0]
- `int2`  out  1  DATA_READY & INTMAP2[0]

## Operation
- **Input synchronisation.** `sck_i`, `ncs_i` and `mosi_i` each pass through a 2-flop synchroniser. Rise and fall events come from comparing the synchronised value with its previous-cycle value. `mosi_i` is sampled on a synchronised SCK rise. MISO shifts on a synchronised SCK fall.
- **Register map.**
  - 0x00–0x03: ID values (read-only).
  - 0x08/0x09/0x0A: `x_data[11:4]`, `y_data[11:4]`, `z_data[11:4]`.
  - 0x0B STATUS: bit0 = DATA_READY; other bits read 0.
  - 0x0E–0x13: XL, XH, YL, YH, ZL, ZH. L = bits[7:0]. H = {4 copies of bit 11, bits[11:8]}.
  - 0x1F SOFT_RESET: write-only, reads 0.
  - 0x20–0x2E: read/write general registers, reset 0x00. 0x2A = INTMAP1, 0x2B = INTMAP2.
  - All other addresses read 0x00 and ignore writes.
- **Sample capture.** `sample_valid` loads the live sample registers and sets DATA_READY.
  - While `ncs_i` is low, the shadow copy frozen at the `ncs_i` falling edge is served, so multibyte reads are coherent.
  - DATA_READY clears when the 8th bit of a read of any address in 0x08–0x0A or 0x0E–0x13 completes.
  - If that clear and a `sample_valid` occur in the same cycle, set wins.
- **State machine.**
  - IDLE → CMD on `ncs_i` falling.
  - CMD: shift 8 bits. 0x0A → ADDR_W; 0x0B → ADDR_R; any other value → IGNORE.
  - ADDR_W / ADDR_R: shift 8 bits; address = bits[5:0], bits[7:6] ignored. ADDR_R loads the byte at that address into the MISO shift register on the 8th rise. Both then go to DATA_W or DATA_R.
  - DATA_W: on every 8th rise, write the byte (honouring read-only and ignored addresses), then increment the address.
  - DATA_R: on every 8th rise, increment the address and load the next byte.
  - Address wraps 0x3F → 0x00.
  - IGNORE: consume bits, `miso_o` = 0.
  - Any `ncs_i` rise returns to IDLE from any state. The bit counter clears, and a partial byte is discarded with no write.
- **Soft reset.** Writing 0x52 to 0x1F clears 0x20–0x2E and DATA_READY at the end of that byte. Any other value written to 0x1F has no effect.
- **MISO output.** `miso_o` = shift[7] in DATA_R, else 0. It is a plain output (not tristated).

## Timing
- Reset (`reset` = 0) applies at once: state IDLE, `miso_o` = 0, `int1` = `int2` = 0, DATA_READY = 0, registers 0x20–0x2E = 0x00, samples = 0. An active transaction is abandoned. After reset releases, the block waits for a fresh `ncs_i` falling edge.
- Edge-detect latency is 3 `clk` from a pin change to the internal event.
- The read byte is loaded within 1 `clk` of the 8th-rise event. Its MSB appears on `miso_o` 1 `clk` after the next fall event.
- The master samples MISO on the SCK rising edge. With a 4-clk minimum SCK half period, MISO is stable for at least 1 `clk` before that rising edge.
- Writes commit 1 `clk` after the 8th-rise event.
- `int1`/`int2` are registered, asserting 1 `clk` after DATA_READY changes.

## Test plan
- **ID read.** Master sends 0x0B 0x00 followed by 4 dummy bytes. MISO returns AD 1D F2 01.
- **Write then read-back.** Write 0x0A 0x2A 0x01, then read 0x0B 0x2A. Read returns 0x01. Pulsing `sample_valid` with x = 0x123 then asserts `int1` within 2 `clk`; `int2` stays 0.
- **Coherent burst.**
  - Pulse `sample_valid` with x = 0x8F0, y = 0x7FF, z = 0x001.
  - Begin a burst read at 0x0E. Mid-transaction, pulse `sample_valid` with all axes = 0.
  - Required bytes: F0 F8 FF 07 01 00.
  - After `ncs_i` rises, DATA_READY = 1 (set by the second sample).
  - The next read of 0x0B returns 0x01.
- **Wrap and read-only.** Write 0x0A 0x3F 0xAA 0x55. Read 0x00 returns 0xAD (unchanged) and read 0x3F returns 0x00.
- **Abort and illegal command.**
  - `ncs_i` rises after 5 bits of data byte 0x77 written to 0x21. Reg 0x21 stays 0x00.
  - Command 0x0D: `miso_o` stays 0 throughout.
- **Resets.** Async `reset` mid-burst gives `miso_o` = 0 and clears 0x20–0x2E. Writing 0x52 to 0x1F clears 0x20–0x2E and drops `int1`.
